sync_ram_dp: RTL and testbench
==============================

Name: sync_ram_dp

Overview:
Parametrised simple-dual-port synchronous RAM: one write port and one independent read port on a single clock. It is the successor to the fixed 256x32 single-port synchronous RAM.
- Adds per-byte write enables and a selectable read-during-write policy.
- Adds an optional output pipeline register and a read-valid strobe.
- Adds a post-reset zero-fill sweep, so contents are defined before first use.
- Sits between the datapath and local storage wherever a scratch or table memory is needed.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 8, address width; depth = 2**ADDR_W.
- OUT_REG, 0, 1 adds an output register stage, giving read latency 2 instead of 1.
- RDW_MODE, 0, same-address read/write collision policy: 0 = read-first (old data), 1 = write-first (new merged data).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_be  in  DATA_W/8  byte write enables; bit i covers data bits [8i+7:8i].
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  one-cycle strobe; rd_data is valid while it is high.
- init_done  out  1  high once the zero-fill sweep has completed.
- rd_perr  out  1  parity error flag (see Optional Feature).

Behaviour:
- Reset: synchronous and active-high; it is sampled on clk.
  - Outputs after reset: rd_data=0, rd_valid=0, init_done=0, rd_perr=0.
  - Any read in flight in the pipeline is dropped.
- State machine: INIT -> READY.
  - INIT:
    - Writes all-zero to address cnt, where cnt runs 0..2**ADDR_W-1, one word per cycle.
    - wr_en and rd_en are ignored; rd_valid stays 0.
    - Leaves INIT after the last address is written; init_done rises on that same edge.
    - The sweep therefore takes exactly 2**ADDR_W cycles after rst deasserts.
  - READY: normal operation; the FSM stays here until the next rst.
  - rst asserted in any state, including mid-sweep: return to INIT and restart from address 0.
- Write (READY, wr_en=1):
  - Only the bytes whose wr_be bit is 1 are updated at the clock edge.
  - wr_be=0 with wr_en=1 is a no-op.
- Read (READY, rd_en=1):
  - OUT_REG=0: rd_data and rd_valid are updated on the next edge (latency 1).
  - OUT_REG=1: latency 2.
  - Back-to-back reads give one result per cycle (full throughput).
  - rd_data holds its last value when no read completes; rd_valid is high only in completion cycles.
- Collision (same-cycle wr_en and rd_en, wr_addr==rd_addr):
  - RDW_MODE=0 returns the pre-write word.
  - RDW_MODE=1 returns the word after the wr_be byte merge.
- Writes and reads to different addresses in the same cycle are independent.
- Addresses have no out-of-range case: depth equals 2**ADDR_W.

Optional Feature:
- Macro: SYNC_RAM_PARITY_EN.
- Defined:
  - Each stored byte carries one even-parity bit, computed on write and during the zero-fill.
  - On read, parity is recomputed. rd_perr pulses together with rd_valid if any byte of the word mismatches.
  - The parity bits follow the same RDW_MODE and OUT_REG timing as the data.
- Undefined: no parity storage; rd_perr is tied to 0.

Decomposition:
- Shared package sync_ram_pkg holds:
  - FSM state encoding (ST_INIT, ST_READY).
  - RDW_READ_FIRST=0 and RDW_WRITE_FIRST=1 constants.
  - A byte-parity function.
- One natural sub-module: sync_ram_bytemerge, a combinational old/new merge under wr_be. Both the storage write path and the write-first bypass use it.

Test Plan:
All scenarios use DATA_W=32, ADDR_W=8 unless stated.
1. Reset then idle: rst high for 2 cycles, then low -> init_done rises exactly 256 cycles later; afterwards a read of addr 0x55 returns 0x00000000 with rd_valid.
2. Write/read, OUT_REG=0: write 0x12345678 to addr 10, wr_be=4'hF, then read addr 10 -> rd_data=0x12345678 and rd_valid=1 one cycle after rd_en.
3. Byte enables: write 0xAABBCCDD to addr 20, then write 0x11223344 with wr_be=4'b0101 -> a read of addr 20 returns 0xAA22CC44.
4. Collision at addr 20 (holding 0xAABBCCDD), writing 0x00000000 with full enables and reading in the same cycle:
   - RDW_MODE=0 -> read returns 0xAABBCCDD.
   - RDW_MODE=1 -> read returns 0x00000000.
5. OUT_REG=1 streaming: rd_en high for 4 cycles over addrs 10, 20, 10, 20 -> rd_valid high for 4 consecutive cycles starting 2 cycles after the first rd_en, with the matching data in order.
6. Reset mid-sweep plus request masking:
   - Assert rst for 1 cycle at INIT cycle 100 -> init_done rises 256 cycles after that rst deasserts.
   - wr_en issued during INIT is ignored: addr 10 still reads 0.
   - With SYNC_RAM_PARITY_EN, rd_perr=0 throughout.

Source files
------------

// File: rtl/sync_ram_pkg.sv
// sync_ram_pkg: shared FSM encoding, read-during-write policy constants and byte parity helper
package sync_ram_pkg;
    typedef enum logic {ST_INIT, ST_READY} state_e;
    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction
endpackage

// File: rtl/sync_ram_bytemerge.sv
// sync_ram_bytemerge: combinational merge of new bytes over an old word under byte enables
// Ports: old_data/new_data in, be in (bit i selects new_data byte i), merged out.
module sync_ram_bytemerge #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   old_data,
    input  logic [DATA_W-1:0]   new_data,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   merged
);
    genvar i;
    for (i = 0; i < DATA_W / 8; i++) begin : g_byte
        assign merged[8*i +: 8] = be[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
    end
endmodule

// File: rtl/sync_ram_dp.sv
// sync_ram_dp: simple-dual-port synchronous RAM with byte enables, zero-fill sweep and optional parity
// Ports: clk, rst (sync, active high); write port wr_en/wr_addr/wr_be/wr_data;
// read port rd_en/rd_addr -> rd_data/rd_valid/rd_perr; init_done after the zero-fill.
// Macro SYNC_RAM_PARITY_EN adds one even-parity bit per stored byte; otherwise rd_perr is 0.
module sync_ram_dp
    import sync_ram_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int OUT_REG  = 0,
    parameter int RDW_MODE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                init_done,
    output logic                rd_perr
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;
    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                init_done_q, init_done_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                ready, we, rd_fire, bypass, rperr;
    logic [ADDR_W-1:0]   waddr;
    logic [NB-1:0]       wbe;
    logic [DATA_W-1:0]   wdata, wold, wmerged, rword;
    logic                v1_q, v1_d, v2_q, v2_d, p1_q, p1_d, p2_q, p2_d;
    logic [DATA_W-1:0]   d1_q, d1_d, d2_q, d2_d;

    sync_ram_bytemerge #(.DATA_W(DATA_W)) u_merge (
        .old_data(wold),
        .new_data(wdata),
        .be      (wbe),
        .merged  (wmerged)
    );

    // During INIT the write port is hijacked by the sweep: full-enable zero writes at cnt.
    always_comb begin
        ready       = state_q == ST_READY;
        we          = !rst && (!ready || wr_en);
        waddr       = ready ? wr_addr : cnt_q;
        wbe         = ready ? wr_be : '1;
        wdata       = ready ? wr_data : '0;
        wold        = mem_q[waddr];
        rd_fire     = ready && rd_en;
        bypass      = RDW_MODE == RDW_WRITE_FIRST && ready && wr_en && wr_addr == rd_addr;
        rword       = bypass ? wmerged : mem_q[rd_addr];
        cnt_d       = ready ? cnt_q : cnt_q + ADDR_W'(1);
        state_d     = (!ready && &cnt_q) ? ST_READY : state_q;
        init_done_d = state_d == ST_READY;
        v1_d        = rd_fire;
        d1_d        = rd_fire ? rword : d1_q;
        p1_d        = rd_fire && rperr;
        v2_d        = v1_q;
        d2_d        = v1_q ? d1_q : d2_q;
        p2_d        = p1_q;
    end

`ifdef SYNC_RAM_PARITY_EN
    logic [NB-1:0] par_q [DEPTH];
    logic [NB-1:0] wpar, rpar_calc, rpar_st;
    always_comb begin
        wpar      = '0;
        rpar_calc = '0;
        for (int i = 0; i < NB; i++) begin
            wpar[i]      = byte_parity(wmerged[8*i +: 8]);
            rpar_calc[i] = byte_parity(rword[8*i +: 8]);
        end
        rpar_st = bypass ? wpar : par_q[rd_addr];
        rperr   = |(rpar_calc ^ rpar_st);
    end
    always_ff @(posedge clk) begin
        if (we) par_q[waddr] <= wpar;
    end
`else
    assign rperr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wmerged;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            v1_q        <= 1'b0;
            d1_q        <= '0;
            p1_q        <= 1'b0;
            v2_q        <= 1'b0;
            d2_q        <= '0;
            p2_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            v1_q        <= v1_d;
            d1_q        <= d1_d;
            p1_q        <= p1_d;
            v2_q        <= v2_d;
            d2_q        <= d2_d;
            p2_q        <= p2_d;
        end
    end

    assign rd_data   = OUT_REG != 0 ? d2_q : d1_q;
    assign rd_valid  = OUT_REG != 0 ? v2_q : v1_q;
    assign rd_perr   = OUT_REG != 0 ? p2_q : p1_q;
    assign init_done = init_done_q;
endmodule

// File: tb/tb_sync_ram_dp.sv
// tb_sync_ram_dp: randomized and directed bench for two sync_ram_dp configurations against an array model
module tb_sync_ram_dp;
    logic        clk = 1'b0;
    logic        rst, wr_en, rd_en;
    logic [7:0]  wr_addr, rd_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic [31:0] rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1, init_done0, init_done1, rd_perr0, rd_perr1;
    int          checks = 0, failures = 0;

    logic [31:0] mem_m [256];
    bit          ready_m;
    int          init_left;
    bit          ev0, ev1, pv;
    logic [31:0] ed0, ed1, pd;

    always #5 clk = ~clk;

    sync_ram_dp #(.DATA_W(32), .ADDR_W(8), .OUT_REG(0), .RDW_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0),
        .init_done(init_done0), .rd_perr(rd_perr0)
    );

    sync_ram_dp #(.DATA_W(32), .ADDR_W(8), .OUT_REG(1), .RDW_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .init_done(init_done1), .rd_perr(rd_perr1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle, advance the model across the edge, then compare both DUTs.
    task automatic cyc(input bit r, input bit we, input logic [7:0] wa, input logic [3:0] be,
                       input logic [31:0] wd, input bit re, input logic [7:0] ra);
        logic [31:0] old, mrg, wf;
        rst = r; wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd; rd_en = re; rd_addr = ra;
        if (r) begin
            ready_m = 0; init_left = 256;
            ev0 = 0; ed0 = '0; ev1 = 0; ed1 = '0; pv = 0; pd = '0;
        end else begin
            old = mem_m[ra];
            mrg = mem_m[wa];
            for (int i = 0; i < 4; i++) if (be[i]) mrg[8*i +: 8] = wd[8*i +: 8];
            wf  = (ready_m && we && wa == ra) ? mrg : old;
            ev1 = pv;
            if (pv) ed1 = pd;
            pv = ready_m && re;
            if (pv) pd = wf;
            ev0 = ready_m && re;
            if (ev0) ed0 = old;
            if (ready_m && we) mem_m[wa] = mrg;
            if (!ready_m) begin
                init_left--;
                if (init_left == 0) begin
                    ready_m = 1;
                    foreach (mem_m[i]) mem_m[i] = '0;
                end
            end
        end
        @(negedge clk);
        chk("init_done0", 32'(init_done0), 32'(ready_m));
        chk("init_done1", 32'(init_done1), 32'(ready_m));
        chk("rd_valid0", 32'(rd_valid0), 32'(ev0));
        chk("rd_valid1", 32'(rd_valid1), 32'(ev1));
        chk("rd_data0", rd_data0, ed0);
        chk("rd_data1", rd_data1, ed1);
        chk("rd_perr0", 32'(rd_perr0), 32'd0);
        chk("rd_perr1", 32'(rd_perr1), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 8'h0, 4'h0, 32'h0, 0, 8'h0);
    endtask

    initial begin
        cyc(1, 0, 8'h0, 4'h0, 32'h0, 0, 8'h0);
        cyc(1, 0, 8'h0, 4'h0, 32'h0, 0, 8'h0);
        idle(255);
        chk("init_at_255", 32'(init_done0), 32'd0);
        idle(1);
        chk("init_at_256", 32'(init_done0), 32'd1);
        cyc(0, 0, 8'h0, 4'h0, 32'h0, 1, 8'h55);
        chk("rd55_valid", 32'(rd_valid0), 32'd1);
        chk("rd55_data", rd_data0, 32'h0);
        idle(2);
        cyc(0, 1, 8'd10, 4'hF, 32'h12345678, 0, 8'h0);
        cyc(0, 0, 8'h0, 4'h0, 32'h0, 1, 8'd10);
        chk("rd10", rd_data0, 32'h12345678);
        cyc(0, 1, 8'd20, 4'hF, 32'hAABBCCDD, 0, 8'h0);
        cyc(0, 1, 8'd20, 4'b0101, 32'h11223344, 0, 8'h0);
        cyc(0, 0, 8'h0, 4'h0, 32'h0, 1, 8'd20);
        chk("be_merge", rd_data0, 32'hAA22CC44);
        cyc(0, 1, 8'd20, 4'hF, 32'hAABBCCDD, 0, 8'h0);
        cyc(0, 1, 8'd20, 4'hF, 32'h0, 1, 8'd20);
        chk("rdw_read_first", rd_data0, 32'hAABBCCDD);
        idle(1);
        chk("rdw_write_first", rd_data1, 32'h0);
        cyc(0, 1, 8'd20, 4'hF, 32'hAABBCCDD, 0, 8'h0);
        cyc(0, 0, 8'h0, 4'h0, 32'h0, 1, 8'd10);
        chk("stream_lat2_idle", 32'(rd_valid1), 32'd0);
        cyc(0, 0, 8'h0, 4'h0, 32'h0, 1, 8'd20);
        chk("stream_first", rd_data1, 32'h12345678);
        cyc(0, 0, 8'h0, 4'h0, 32'h0, 1, 8'd10);
        chk("stream_second", rd_data1, 32'hAABBCCDD);
        cyc(0, 0, 8'h0, 4'h0, 32'h0, 1, 8'd20);
        idle(3);
        cyc(1, 0, 8'h0, 4'h0, 32'h0, 0, 8'h0);
        repeat (100) cyc(0, 1, 8'd10, 4'hF, $urandom, 1, 8'd10);
        cyc(1, 0, 8'h0, 4'h0, 32'h0, 0, 8'h0);
        repeat (256) cyc(0, 1, 8'd10, 4'hF, $urandom, 0, 8'h0);
        chk("mid_reset_done", 32'(init_done0), 32'd1);
        cyc(0, 0, 8'h0, 4'h0, 32'h0, 1, 8'd10);
        chk("masked_write", rd_data0, 32'h0);
        repeat (3000) cyc($urandom_range(999) == 0, 1'($urandom), 8'($urandom_range(7)), 4'($urandom),
                          $urandom, 1'($urandom), 8'($urandom_range(7)));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
